// File: rtl/cplx_fixed_pkg.sv
// -----------------------------------------------------------------------------
// cplx_fixed_pkg
// Shared fixed-point helpers for the complex datapath.
//   wide_w   : bit width of a Q(QI+1).QF component (adder output format)
//   narrow_w : bit width of a QI.QF component (requantised format)
//   work_w   : internal width used while negating/rounding (one guard bit
//              above the wide format so -(-2^(W-1)) and x+1 cannot overflow)
//   sat_max / sat_min : raw integer limits of the QI.QF format
//   cplx_t   : complex sample pair in the default QI.QF format
// -----------------------------------------------------------------------------
package cplx_fixed_pkg;

  localparam int QI_DEF = 3;
  localparam int QF_DEF = 3;

  function automatic int wide_w(input int qi, input int qf);
    return qi + qf + 1;
  endfunction

  function automatic int narrow_w(input int qi, input int qf);
    return qi + qf;
  endfunction

  function automatic int work_w(input int qi, input int qf);
    return qi + qf + 2;
  endfunction

  function automatic int sat_max(input int qi, input int qf);
    return (32'sd1 <<< (qi + qf - 1)) - 32'sd1;
  endfunction

  function automatic int sat_min(input int qi, input int qf);
    return -(32'sd1 <<< (qi + qf - 1));
  endfunction

  typedef struct packed {
    logic signed [QI_DEF+QF_DEF-1:0] re;
    logic signed [QI_DEF+QF_DEF-1:0] im;
  } cplx_t;

endpackage

// File: rtl/complex_requant_if.sv
// -----------------------------------------------------------------------------
// complex_requant_if
// Stream bundle around complex_requant.
//   s_valid/s_ready/s_Re/s_Im/scale(/conj) : input beat, Q(QI+1).QF
//   m_valid/m_ready/m_Re/m_Im              : output beat, QI.QF
// Modports:
//   slave  : the requantiser's view (consumes s_*, produces m_*)
//   master : the environment's view (produces s_*, consumes m_*)
// Optional macro COMPLEX_REQUANT_CONJ_EN adds the conj signal.
// -----------------------------------------------------------------------------
interface complex_requant_if
  import cplx_fixed_pkg::*;
#(
  parameter int QI = 3,
  parameter int QF = 3
);

  logic                             s_valid;
  logic                             s_ready;
  logic signed [wide_w(QI,QF)-1:0]  s_Re;
  logic signed [wide_w(QI,QF)-1:0]  s_Im;
  logic                             scale;
`ifdef COMPLEX_REQUANT_CONJ_EN
  logic                             conj;
`endif
  logic                             m_valid;
  logic                             m_ready;
  logic signed [narrow_w(QI,QF)-1:0] m_Re;
  logic signed [narrow_w(QI,QF)-1:0] m_Im;

  modport slave (
`ifdef COMPLEX_REQUANT_CONJ_EN
    input  conj,
`endif
    input  s_valid, s_Re, s_Im, scale, m_ready,
    output s_ready, m_valid, m_Re, m_Im
  );

  modport master (
`ifdef COMPLEX_REQUANT_CONJ_EN
    output conj,
`endif
    output s_valid, s_Re, s_Im, scale, m_ready,
    input  s_ready, m_valid, m_Re, m_Im
  );

endinterface

// File: rtl/sat_round_lane.sv
// -----------------------------------------------------------------------------
// sat_round_lane
// One component lane of the requantiser, purely combinational, split into
// two halves so the parent can place a pipeline register between them.
//   Stage-1 half: x_i (Q(QI+1).QF), scale_i, [neg_i] -> y_o (work width)
//   Stage-2 half: y_i (work width) -> q_o (QI.QF), sat_o (clip happened)
// Optional macro COMPLEX_REQUANT_CONJ_EN adds neg_i (negate before scaling).
// -----------------------------------------------------------------------------
module sat_round_lane
  import cplx_fixed_pkg::*;
#(
  parameter int QI = 3,
  parameter int QF = 3
) (
  input  logic signed [wide_w(QI,QF)-1:0]   x_i,
  input  logic                              scale_i,
`ifdef COMPLEX_REQUANT_CONJ_EN
  input  logic                              neg_i,
`endif
  output logic signed [work_w(QI,QF)-1:0]   y_o,
  input  logic signed [work_w(QI,QF)-1:0]   y_i,
  output logic signed [narrow_w(QI,QF)-1:0] q_o,
  output logic                              sat_o
);

  localparam int WI = wide_w(QI, QF);
  localparam int WK = work_w(QI, QF);
  localparam int WO = narrow_w(QI, QF);

  localparam logic signed [WK-1:0] MAX_K = WK'(sat_max(QI, QF));
  localparam logic signed [WK-1:0] MIN_K = WK'(sat_min(QI, QF));
  localparam logic signed [WK-1:0] ONE_K = {{(WK-1){1'b0}}, 1'b1};

  logic signed [WK-1:0] x_ext;
  logic signed [WK-1:0] v;
  logic signed [WK-1:0] v_inc;

  // Stage-1 arithmetic: sign-extend, optional negate, optional round-half-up halving.
  always_comb begin
    x_ext = {x_i[WI-1], x_i};
`ifdef COMPLEX_REQUANT_CONJ_EN
    if (neg_i) begin
      v = -x_ext;
    end else begin
      v = x_ext;
    end
`else
    v = x_ext;
`endif
    v_inc = v + ONE_K;
    if (scale_i) begin
      // (x + 1) >>> 1 rounds ties toward +inf
      y_o = v_inc >>> 1;
    end else begin
      y_o = v;
    end
  end

  // Stage-2 saturation into the narrow format.
  always_comb begin
    q_o   = y_i[WO-1:0];
    sat_o = 1'b0;
    if (y_i > MAX_K) begin
      q_o   = MAX_K[WO-1:0];
      sat_o = 1'b1;
    end else if (y_i < MIN_K) begin
      q_o   = MIN_K[WO-1:0];
      sat_o = 1'b1;
    end else begin
      q_o   = y_i[WO-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/complex_requant.sv
// -----------------------------------------------------------------------------
// complex_requant
// Two-stage streaming narrowing of a complex sample from Q(QI+1).QF to QI.QF:
// stage 1 optionally halves with rounding, stage 2 saturates. Elastic
// valid/ready pipeline with full throughput, plus a sticky saturation flag
// and a non-wrapping saturation-event counter.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : complex_requant_if.slave (input and output beats)
//   clear      : synchronous clear of sat_flag / sat_count
//   sat_flag   : sticky, some component clipped since reset/clear
//   sat_count  : number of beats with at least one clipped component
// Optional macro COMPLEX_REQUANT_CONJ_EN: bus.conj negates the imaginary part.
// -----------------------------------------------------------------------------
module complex_requant
  import cplx_fixed_pkg::*;
#(
  parameter int QI    = 3,
  parameter int QF    = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  complex_requant_if.slave   bus,
  input  logic               clear,
  output logic               sat_flag,
  output logic [CNT_W-1:0]   sat_count
);

  localparam int WK = work_w(QI, QF);
  localparam int WO = narrow_w(QI, QF);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // stage 1
  logic                 v1_q, v1_d;
  logic signed [WK-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
  // stage 2
  logic                 v2_q, v2_d;
  logic signed [WO-1:0] m_re_q, m_re_d, m_im_q, m_im_d;
  // statistics
  logic                 flag_q, flag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 en1, en2, sat_evt;
  logic signed [WK-1:0] y_re_c, y_im_c;
  logic signed [WO-1:0] q_re_c, q_im_c;
  logic                 sat_re_c, sat_im_c;

  sat_round_lane #(.QI(QI), .QF(QF)) u_lane_re (
    .x_i     (bus.s_Re),
    .scale_i (bus.scale),
`ifdef COMPLEX_REQUANT_CONJ_EN
    .neg_i   (1'b0),
`endif
    .y_o     (y_re_c),
    .y_i     (y_re_q),
    .q_o     (q_re_c),
    .sat_o   (sat_re_c)
  );

  sat_round_lane #(.QI(QI), .QF(QF)) u_lane_im (
    .x_i     (bus.s_Im),
    .scale_i (bus.scale),
`ifdef COMPLEX_REQUANT_CONJ_EN
    .neg_i   (bus.conj),
`endif
    .y_o     (y_im_c),
    .y_i     (y_im_q),
    .q_o     (q_im_c),
    .sat_o   (sat_im_c)
  );

  // Handshake: a stage may load when it is empty or its content moves on.
  assign en2         = ~v2_q | bus.m_ready;
  assign en1         = ~v1_q | en2;
  assign bus.s_ready = en1;
  assign sat_evt     = en2 & v1_q & (sat_re_c | sat_im_c);

  // Next-state for both pipeline stages and the saturation statistics.
  always_comb begin
    v1_d   = v1_q;
    y_re_d = y_re_q;
    y_im_d = y_im_q;
    v2_d   = v2_q;
    m_re_d = m_re_q;
    m_im_d = m_im_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;

    if (en1) begin
      v1_d = bus.s_valid;
      if (bus.s_valid) begin
        y_re_d = y_re_c;
        y_im_d = y_im_c;
      end else begin
        y_re_d = y_re_q;
        y_im_d = y_im_q;
      end
    end else begin
      v1_d = v1_q;
    end

    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        m_re_d = q_re_c;
        m_im_d = q_im_c;
      end else begin
        m_re_d = m_re_q;
        m_im_d = m_im_q;
      end
    end else begin
      v2_d = v2_q;
    end

    // A coinciding event beats clear: the event becomes the first count.
    if (sat_evt) begin
      flag_d = 1'b1;
      if (clear) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else if (clear) begin
      flag_d = 1'b0;
      cnt_d  = CNT_ZERO;
    end else begin
      flag_d = flag_q;
      cnt_d  = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      y_re_q <= {WK{1'b0}};
      y_im_q <= {WK{1'b0}};
      v2_q   <= 1'b0;
      m_re_q <= {WO{1'b0}};
      m_im_q <= {WO{1'b0}};
      flag_q <= 1'b0;
      cnt_q  <= CNT_ZERO;
    end else begin
      v1_q   <= v1_d;
      y_re_q <= y_re_d;
      y_im_q <= y_im_d;
      v2_q   <= v2_d;
      m_re_q <= m_re_d;
      m_im_q <= m_im_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.m_valid = v2_q;
  assign bus.m_Re    = m_re_q;
  assign bus.m_Im    = m_im_q;
  assign sat_flag    = flag_q;
  assign sat_count   = cnt_q;

endmodule

// File: tb/tb_complex_requant.sv
module tb_complex_requant;

  localparam int QI    = 3;
  localparam int QF    = 3;
  localparam int CNT_W = 2;
  localparam int MAXV  = (1 << (QI + QF - 1)) - 1;
  localparam int MINV  = -(1 << (QI + QF - 1));
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             sat_flag;
  logic [CNT_W-1:0] sat_count;

  complex_requant_if #(.QI(QI), .QF(QF)) bus ();

  complex_requant #(.QI(QI), .QF(QF), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .clear     (clear),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: beat waiting in the middle slot, beat presented at the output
  bit mid_v, out_v, mid_sat, m_flag;
  int mid_re, mid_im, out_re, out_im, m_cnt;

  bit capture_en = 1'b0;
  int cap_re[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Spec arithmetic: optional negate, optional (x+1)/2 floored, clip.
  function automatic int rq_raw(input int x, input bit sc, input bit ng);
    int t;
    t = ng ? -x : x;
    if (sc) t = (t + 1) >>> 1;
    return t;
  endfunction

  function automatic int rq_val(input int x, input bit sc, input bit ng);
    int t;
    t = rq_raw(x, sc, ng);
    if (t > MAXV) return MAXV;
    if (t < MINV) return MINV;
    return t;
  endfunction

  function automatic bit rq_sat(input int x, input bit sc, input bit ng);
    int t;
    t = rq_raw(x, sc, ng);
    return (t > MAXV) || (t < MINV);
  endfunction

  function automatic bit cur_conj();
`ifdef COMPLEX_REQUANT_CONJ_EN
    return bus.conj;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_beat(input int re, input int im, input bit sc, input bit cj);
    bus.s_Re  = 7'(re);
    bus.s_Im  = 7'(im);
    bus.scale = sc;
`ifdef COMPLEX_REQUANT_CONJ_EN
    bus.conj  = cj;
`else
    if (cj) begin end
`endif
  endtask

  // One clock: check ready, advance model at the edge, check outputs after.
  task automatic step(output bit acc);
    bit a1, a2, evt;
    int sre, sim;
    bit ssat;
    #1;
    a2 = !out_v || bus.m_ready;
    a1 = !mid_v || a2;
    chk("s_ready", int'(bus.s_ready), int'(a1));
    acc = !rst && bus.s_valid && a1;
    if (capture_en && bus.m_valid && bus.m_ready) cap_re.push_back(int'(bus.m_Re));
    sre  = rq_val(int'(bus.s_Re), bus.scale, 1'b0);
    sim  = rq_val(int'(bus.s_Im), bus.scale, cur_conj());
    ssat = rq_sat(int'(bus.s_Re), bus.scale, 1'b0) || rq_sat(int'(bus.s_Im), bus.scale, cur_conj());
    @(posedge clk);
    if (rst) begin
      mid_v = 0; out_v = 0; m_flag = 0; m_cnt = 0; out_re = 0; out_im = 0;
    end else begin
      evt = 0;
      if (a2) begin
        out_v = mid_v;
        if (mid_v) begin out_re = mid_re; out_im = mid_im; evt = mid_sat; end
      end
      if (evt) begin
        m_flag = 1;
        m_cnt  = clear ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
      end else if (clear) begin
        m_flag = 0; m_cnt = 0;
      end
      if (a1) begin
        mid_v = bus.s_valid;
        if (bus.s_valid) begin mid_re = sre; mid_im = sim; mid_sat = ssat; end
      end
    end
    @(negedge clk);
    chk("m_valid", int'(bus.m_valid), int'(out_v));
    chk("sat_flag", int'(sat_flag), int'(m_flag));
    chk("sat_count", int'(sat_count), m_cnt);
    if (out_v) begin
      chk("m_Re", int'(bus.m_Re), out_re);
      chk("m_Im", int'(bus.m_Im), out_im);
    end
  endtask

  task automatic send(input int re, input int im, input bit sc);
    bit acc;
    int k;
    set_beat(re, im, sc, 1'b0);
    bus.s_valid = 1'b1;
    acc = 0;
    k = 0;
    while (!acc && k < 20) begin step(acc); k++; end
    if (!acc) chk("send_timeout", 0, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, last_acc;
    int idx;
    int br[3];
    int cur_re, cur_im;
    bit cur_sc, cur_cj;

    // pin the model to hand-computed values
    chk("pin_pass",   rq_val(10, 0, 0), 10);
    chk("pin_clip_hi", rq_val(40, 0, 0), 31);
    chk("pin_clip_lo", rq_val(-50, 0, 0), -32);
    chk("pin_half_pos", rq_val(5, 1, 0), 3);
    chk("pin_half_neg", rq_val(-5, 1, 0), -2);
    chk("pin_half_63", rq_val(63, 1, 0), 31);
    chk("pin_sat_63",  int'(rq_sat(63, 1, 0)), 1);
    chk("pin_half_m64", rq_val(-64, 1, 0), -32);
    chk("pin_neg_m64", rq_val(-64, 0, 1), 31);

    rst = 1; clear = 0;
    bus.s_valid = 0; bus.m_ready = 1;
    set_beat(0, 0, 0, 0);
    mid_v = 0; out_v = 0; m_flag = 0; m_cnt = 0; out_re = 0; out_im = 0;
    mid_re = 0; mid_im = 0; mid_sat = 0;
    @(negedge clk);
    idle(2);
    rst = 0;
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_Re", int'(bus.m_Re), 0);
    chk("rst_m_Im", int'(bus.m_Im), 0);
    chk("rst_count", int'(sat_count), 0);
    idle(1);

    // directed: pass-through and clipping
    send(10, -5, 0); idle(1);
    chk("d1_re", int'(bus.m_Re), 10);
    chk("d1_im", int'(bus.m_Im), -5);
    chk("d1_cnt", int'(sat_count), 0);
    send(40, -50, 0); idle(1);
    chk("d2_re", int'(bus.m_Re), 31);
    chk("d2_im", int'(bus.m_Im), -32);
    chk("d2_flag", int'(sat_flag), 1);
    chk("d2_cnt", int'(sat_count), 1);
    // directed: halving, back to back
    send(5, -5, 1);
    send(63, -64, 1);
    chk("d3_re", int'(bus.m_Re), 3);
    chk("d3_im", int'(bus.m_Im), -2);
    chk("d3_cnt", int'(sat_count), 1);
    idle(1);
    chk("d4_re", int'(bus.m_Re), 31);
    chk("d4_im", int'(bus.m_Im), -32);
    chk("d4_cnt", int'(sat_count), 2);
    idle(3);

    // stall: 3 beats offered, m_ready low for 6 cycles
    br[0] = 1; br[1] = 3; br[2] = 5;
    cap_re.delete();
    capture_en = 1;
    bus.m_ready = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      set_beat(br[idx], idx, 0, 0);
      bus.s_valid = 1;
      step(acc);
      if (acc) idx++;
    end
    chk("stall_accepted", idx, 2);
    #1 chk("stall_s_ready", int'(bus.s_ready), 0);
    @(negedge clk);
    bus.m_ready = 1;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      set_beat(br[idx], idx, 0, 0);
      bus.s_valid = 1;
      step(acc);
      if (acc) idx++;
    end
    bus.s_valid = 0;
    idle(4);
    capture_en = 0;
    chk("stall_delivered", cap_re.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("stall_order", (i < cap_re.size()) ? cap_re[i] : -99, br[i]);

    // reset with two beats in flight
    send(20, 20, 0);
    send(21, 21, 0);
    rst = 1; idle(1); rst = 0;
    chk("rst2_m_valid", int'(bus.m_valid), 0);
    chk("rst2_cnt", int'(sat_count), 0);
    send(7, 7, 0);
    chk("rst2_lat0", int'(bus.m_valid), 0);
    idle(1);
    chk("rst2_lat_valid", int'(bus.m_valid), 1);
    chk("rst2_lat_re", int'(bus.m_Re), 7);
    idle(2);

    // counter saturation and clear colliding with an event
    for (int i = 0; i < 5; i++) send(40, 0, 0);
    idle(2);
    chk("cnt_hold", int'(sat_count), 3);
    send(0, -60, 0);
    clear = 1;
    idle(1);
    clear = 0;
    chk("clr_evt_flag", int'(sat_flag), 1);
    chk("clr_evt_cnt", int'(sat_count), 1);
    clear = 1; idle(1); clear = 0;
    chk("clr_flag", int'(sat_flag), 0);
    chk("clr_cnt", int'(sat_count), 0);

    // randomized traffic against the model
    last_acc = 1;
    cur_re = 0; cur_im = 0; cur_sc = 0; cur_cj = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.s_valid && !last_acc)) begin
        bus.s_valid = ($urandom_range(0, 9) < 7);
        cur_re = int'($urandom_range(0, 127)) - 64;
        cur_im = int'($urandom_range(0, 127)) - 64;
        cur_sc = $urandom_range(0, 1);
        cur_cj = $urandom_range(0, 1);
      end
      set_beat(cur_re, cur_im, cur_sc, cur_cj);
      bus.m_ready = ($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step(acc);
      last_acc = acc || rst;
    end
    rst = 0; clear = 0; bus.s_valid = 0; bus.m_ready = 1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
